// File: rtl/dmx_pkg.sv
// dmx_pkg: shared DMX512 constants and the receiver state encoding.
//
// Timing constants assume a 50 MHz system clock (200 cycles per 4 us bit).
// The transmitter timing constants also live here, so transmitter and
// receiver agree on one set of numbers.
package dmx_pkg;

    // Receiver timing
    localparam int DMX_BIT_CYCLES = 200;   // one 250 kbaud bit
    localparam int DMX_BREAK_MIN  = 4400;  // 88 us of continuous low
    localparam int DMX_MAB_MIN    = 400;   // 8 us mark-after-break

    // Transmitter timing
    localparam int DMX_TX_BREAK_CYCLES = 4600;  // 92 us break
    localparam int DMX_TX_MAB_CYCLES   = 600;   // 12 us MAB
    localparam int DMX_TX_SLOT_BITS    = 11;    // start + 8 data + 2 stop

    // Highest slot index: 0 is the start code, 1..512 are channels
    localparam logic [9:0] DMX_MAX_SLOT = 10'd512;

    // Counter widths
    localparam int DMX_LOW_RUN_W = 13;
    localparam int DMX_TIMER_W   = 16;

    typedef enum logic [2:0] {
        HUNT,
        BREAK,
        MAB,
        WAIT_EDGE,
        START,
        DATA,
        STOP1,
        STOP2
    } rx_state_t;

endpackage

// File: rtl/dmx_rx_sync.sv
// dmx_rx_sync: line conditioning for the DMX receiver.
//
// Brings the asynchronous DMX line into the clock domain through two flops,
// flags falling edges of the synchronized line, and counts consecutive low
// samples so the receiver can recognise a break regardless of its state.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   dmx_in       raw serial line, idle high
//   line         synchronized line (2 cycles behind dmx_in)
//   fall         one-cycle strobe on a high-to-low transition of line
//   break_hit    one-cycle strobe when the low run reaches BREAK_MIN
module dmx_rx_sync
    import dmx_pkg::*;
#(
    parameter int BREAK_MIN = DMX_BREAK_MIN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dmx_in,
    output logic line,
    output logic fall,
    output logic break_hit
);

    logic                     meta;
    logic                     line_q;
    logic                     line_d1;
    logic [DMX_LOW_RUN_W-1:0] low_run;

    // NOTE: the synchronizer resets to 1 (idle line) so that releasing reset
    // on a quiet line never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b1;
            line_q  <= 1'b1;
            line_d1 <= 1'b1;
            low_run <= '0;
        end else begin
            meta    <= dmx_in;
            line_q  <= meta;
            line_d1 <= line_q;
            // Saturates so a line held low forever cannot wrap and fake a
            // second break.
            if (line_q) begin
                low_run <= '0;
            end else if (low_run != '1) begin
                low_run <= low_run + 1'b1;
            end
        end
    end

    assign line      = line_q;
    assign fall      = line_d1 & ~line_q;
    // Exact match fires once per low run; the counter keeps climbing after.
    assign break_hit = (low_run == DMX_LOW_RUN_W'(BREAK_MIN));

endmodule

// File: rtl/dmx512_rx.sv
// dmx512_rx: DMX512 receiver.
//
// Recovers break, MAB, start code and up to 512 data slots from a 250 kbaud
// DMX line. Emits one strobe per good slot and one strobe when a packet
// closes (next break, or after slot 512).
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   dmx_in       raw serial DMX line, asynchronous, idle high
//   slot_valid   one-cycle strobe: slot_addr/slot_data valid
//   slot_addr    slot index (0 = start code, 1..512 = channels)
//   slot_data    received slot byte
//   packet_end   one-cycle strobe: slot_count valid
//   slot_count   highest slot index received in the closed packet
//   frame_err    one-cycle strobe: bad stop bit or short MAB
//   rx_active    high from the end of a valid MAB until the packet closes
//
// Build option: define DMX_RX_START_CODE_FILTER_EN to drop every packet whose
// start code is not 8'h00 (no slot strobes, packet_end reports 0 slots).
module dmx512_rx
    import dmx_pkg::*;
#(
    parameter int BIT_CYCLES       = DMX_BIT_CYCLES,
    parameter int BREAK_MIN_CYCLES = DMX_BREAK_MIN,
    parameter int MAB_MIN_CYCLES   = DMX_MAB_MIN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dmx_in,
    output logic       slot_valid,
    output logic [9:0] slot_addr,
    output logic [7:0] slot_data,
    output logic       packet_end,
    output logic [9:0] slot_count,
    output logic       frame_err,
    output logic       rx_active
);

    // Timer is cleared on each event and counts up; sampling points are
    // compared against these constants.
    localparam logic [DMX_TIMER_W-1:0] T_HALF = DMX_TIMER_W'(BIT_CYCLES / 2);
    localparam logic [DMX_TIMER_W-1:0] T_BIT  = DMX_TIMER_W'(BIT_CYCLES - 1);
    // Timer reads (high samples - 1) on the falling edge that ends the MAB.
    localparam logic [DMX_TIMER_W-1:0] T_MAB  = DMX_TIMER_W'(MAB_MIN_CYCLES - 1);

    logic line;
    logic fall;
    logic break_hit;

    dmx_rx_sync #(
        .BREAK_MIN (BREAK_MIN_CYCLES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .dmx_in    (dmx_in),
        .line      (line),
        .fall      (fall),
        .break_hit (break_hit)
    );

    rx_state_t              state;
    rx_state_t              state_next;
    logic [DMX_TIMER_W-1:0] timer;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic [9:0]             slot_idx;

    logic timer_clr;
    logic shift_en;
    logic slot_done;
    logic err;
    logic pkt_start;
    logic suppress;
    logic block_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        shift_en   = 1'b0;
        slot_done  = 1'b0;
        err        = 1'b0;
        pkt_start  = 1'b0;

        unique case (state)
            HUNT: ;
            BREAK: begin
                if (line) begin
                    state_next = MAB;
                    timer_clr  = 1'b1;
                end
            end
            MAB: begin
                if (fall) begin
                    timer_clr = 1'b1;
                    if (timer < T_MAB) begin
                        err        = 1'b1;
                        state_next = HUNT;
                    end else begin
                        pkt_start  = 1'b1;
                        state_next = START;
                    end
                end
            end
            WAIT_EDGE: begin
                if (fall) begin
                    state_next = START;
                    timer_clr  = 1'b1;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (timer == T_HALF) begin
                    timer_clr  = 1'b1;
                    state_next = line ? WAIT_EDGE : DATA;
                end
            end
            DATA: begin
                if (timer == T_BIT) begin
                    timer_clr = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP1;
                    end
                end
            end
            STOP1: begin
                if (timer == T_BIT) begin
                    timer_clr = 1'b1;
                    if (!line) begin
                        err        = 1'b1;
                        state_next = HUNT;
                    end else begin
                        state_next = STOP2;
                    end
                end
            end
            STOP2: begin
                if (timer == T_BIT) begin
                    timer_clr = 1'b1;
                    if (!line) begin
                        err        = 1'b1;
                        state_next = HUNT;
                    end else begin
                        slot_done  = 1'b1;
                        state_next = (slot_idx == DMX_MAX_SLOT) ? HUNT : WAIT_EDGE;
                    end
                end
            end
            default: state_next = HUNT;
        endcase

        // A break wins over anything in flight and drops the partial slot.
        if (break_hit) begin
            state_next = BREAK;
            timer_clr  = 1'b1;
            shift_en   = 1'b0;
            slot_done  = 1'b0;
            err        = 1'b0;
            pkt_start  = 1'b0;
        end
    end

`ifdef DMX_RX_START_CODE_FILTER_EN
    // Decided once per packet, when the start-code slot completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            suppress <= 1'b0;
        end else if (pkt_start) begin
            suppress <= 1'b0;
        end else if (slot_done && slot_idx == 10'd0) begin
            suppress <= (shift_reg != 8'h00);
        end
    end

    // Covers the start-code slot itself, before suppress has been updated.
    assign block_now = suppress | (slot_idx == 10'd0 && shift_reg != 8'h00);
`else
    assign suppress  = 1'b0;
    assign block_now = 1'b0;
`endif

    // NOTE: all state here uses non-blocking assignments so every register
    // sees the values from before the clock edge, whatever the order below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            slot_idx   <= '0;
            slot_valid <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= '0;
            packet_end <= 1'b0;
            slot_count <= '0;
            frame_err  <= 1'b0;
            rx_active  <= 1'b0;
        end else begin
            slot_valid <= 1'b0;
            packet_end <= 1'b0;
            frame_err  <= err;

            if (timer_clr) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + 1'b1;
            end

            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            // LSB arrives first, so shift in from the top.
            if (shift_en) begin
                shift_reg <= {line, shift_reg[7:1]};
            end

            if (pkt_start) begin
                rx_active <= 1'b1;
                slot_idx  <= '0;
            end

            if (slot_done) begin
                slot_valid <= ~block_now;
                slot_addr  <= slot_idx;
                slot_data  <= shift_reg;
                if (slot_idx == DMX_MAX_SLOT) begin
                    packet_end <= 1'b1;
                    slot_count <= block_now ? 10'd0 : DMX_MAX_SLOT;
                    rx_active  <= 1'b0;
                end else begin
                    slot_idx <= slot_idx + 10'd1;
                end
            end

            // slot_idx is one past the highest good slot, so idx != 0 means
            // the open packet holds at least the start code.
            if (break_hit) begin
                rx_active <= 1'b0;
                if (rx_active && slot_idx != 10'd0) begin
                    packet_end <= 1'b1;
                    slot_count <= suppress ? 10'd0 : slot_idx - 10'd1;
                end
            end
        end
    end

endmodule
